// File: rtl/bp_be_int_issue_arb_if.sv
// Issue-arbiter bundle: two requester handshakes, pipe control and the staged
// reservation toward the integer pipe.
interface bp_be_int_issue_arb_if #(
    parameter int reservation_width_p = 128,
    parameter int starve_limit_p      = 4
);
    localparam int cnt_width_lp = $clog2(starve_limit_p + 1);

    logic                           flush_i;
    logic                           stall_i;
    logic                           req0_v_i;
    logic [reservation_width_p-1:0] req0_reservation_i;
    logic                           req0_ready_o;
    logic                           req1_v_i;
    logic [reservation_width_p-1:0] req1_reservation_i;
    logic                           req1_ready_o;
    logic                           v_o;
    logic [reservation_width_p-1:0] reservation_o;
    logic                           src_o;
    logic [cnt_width_lp-1:0]        starve_cnt_o;

    // Requesters and the integer pipe together form the master side.
    modport master (
        output flush_i, stall_i,
        output req0_v_i, req0_reservation_i, req1_v_i, req1_reservation_i,
        input  req0_ready_o, req1_ready_o,
        input  v_o, reservation_o, src_o, starve_cnt_o
    );

    modport slave (
        input  flush_i, stall_i,
        input  req0_v_i, req0_reservation_i, req1_v_i, req1_reservation_i,
        output req0_ready_o, req1_ready_o,
        output v_o, reservation_o, src_o, starve_cnt_o
    );
endinterface

// File: rtl/bp_be_int_issue_arb.sv
// Two-requester fixed-priority issue arbiter with bounded starvation of
// requester 1, feeding a single staging register toward the integer pipe.
module bp_be_int_issue_arb #(
    parameter int reservation_width_p = 128,
    parameter int starve_limit_p      = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    bp_be_int_issue_arb_if.slave  arb_if
);
    localparam int cnt_width_lp = $clog2(starve_limit_p + 1);
    localparam logic [cnt_width_lp-1:0] starve_limit_lp = cnt_width_lp'(starve_limit_p);

    logic                           v_r;
    logic [reservation_width_p-1:0] reservation_r;
    logic                           src_r;
    logic [cnt_width_lp-1:0]        starve_cnt_r;

    logic load;
    logic force1;
    logic grant0;
    logic grant1;
    logic lose1;

    // Reset gating keeps both readies low while reset is held.
    assign load   = ~reset_i & ~arb_if.flush_i & (~v_r | ~arb_if.stall_i);
    assign force1 = (starve_cnt_r == starve_limit_lp);
    assign grant1 = arb_if.req1_v_i & (~arb_if.req0_v_i | force1);
    assign grant0 = arb_if.req0_v_i & ~grant1;
    assign lose1  = arb_if.req0_v_i & arb_if.req1_v_i & grant0;

    assign arb_if.req0_ready_o = load & grant0;
    assign arb_if.req1_ready_o = load & grant1;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            v_r           <= 1'b0;
            reservation_r <= '0;
            src_r         <= 1'b0;
            starve_cnt_r  <= '0;
        end else if (arb_if.flush_i) begin
            v_r          <= 1'b0;
            starve_cnt_r <= '0;
        end else if (load) begin
            v_r <= grant0 | grant1;
            if (grant1) begin
                reservation_r <= arb_if.req1_reservation_i;
                src_r         <= 1'b1;
            end else if (grant0) begin
                reservation_r <= arb_if.req0_reservation_i;
                src_r         <= 1'b0;
            end
            if (grant1) begin
                starve_cnt_r <= '0;
            end else if (lose1 && (starve_cnt_r != starve_limit_lp)) begin
                starve_cnt_r <= starve_cnt_r + cnt_width_lp'(1);
            end
        end
    end

    assign arb_if.v_o           = v_r;
    assign arb_if.reservation_o = reservation_r;
    assign arb_if.src_o         = src_r;
    assign arb_if.starve_cnt_o  = starve_cnt_r;
endmodule

// File: tb/tb_bp_be_int_issue_arb.sv
// Directed bench for the integer issue arbiter: priority, starvation bound,
// stall, flush, empty-stage stall and asynchronous reset.
module tb_bp_be_int_issue_arb;
    localparam int width_lp = 128;
    localparam int limit_lp = 4;

    logic clk_i;
    logic reset_i;
    int   checks;
    int   errors;

    bp_be_int_issue_arb_if #(.reservation_width_p(width_lp), .starve_limit_p(limit_lp)) arb_if ();

    bp_be_int_issue_arb #(.reservation_width_p(width_lp), .starve_limit_p(limit_lp)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .arb_if  (arb_if)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [width_lp-1:0] obs, input logic [width_lp-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic flush, input logic stall,
                         input logic v0, input logic [width_lp-1:0] r0,
                         input logic v1, input logic [width_lp-1:0] r1);
        arb_if.flush_i            = flush;
        arb_if.stall_i            = stall;
        arb_if.req0_v_i           = v0;
        arb_if.req0_reservation_i = r0;
        arb_if.req1_v_i           = v1;
        arb_if.req1_reservation_i = r1;
        #1;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_stage(input string tag, input logic v, input logic [width_lp-1:0] res,
                               input logic src, input int cnt);
        check({tag, "_v"}, width_lp'(arb_if.v_o), width_lp'(v));
        check({tag, "_res"}, arb_if.reservation_o, res);
        check({tag, "_src"}, width_lp'(arb_if.src_o), width_lp'(src));
        check({tag, "_cnt"}, width_lp'(arb_if.starve_cnt_o), width_lp'(cnt));
    endtask

    task automatic check_ready(input string tag, input logic r0, input logic r1);
        check({tag, "_rdy0"}, width_lp'(arb_if.req0_ready_o), width_lp'(r0));
        check({tag, "_rdy1"}, width_lp'(arb_if.req1_ready_o), width_lp'(r1));
    endtask

    initial begin
        logic g1_seq [10];
        int   cnt_seq [10];
        checks  = 0;
        errors  = 0;
        g1_seq  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        cnt_seq = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};

        // Reset: readies must stay low even with both requesters valid.
        reset_i = 1'b1;
        drive(0, 0, 1, 128'h11, 1, 128'h22);
        step();
        check_ready("reset", 0, 0);
        check_stage("reset", 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        reset_i = 1'b0;
        step();

        // Single source A, B, C back to back.
        drive(0, 0, 1, 128'hA, 0, 128'h5);
        check_ready("single_a", 1, 0);
        step();
        check_stage("single_a", 1, 128'hA, 0, 0);
        drive(0, 0, 1, 128'hB, 0, 0);
        check_ready("single_b", 1, 0);
        step();
        check_stage("single_b", 1, 128'hB, 0, 0);
        drive(0, 0, 1, 128'hC, 0, 0);
        step();
        check_stage("single_c", 1, 128'hC, 0, 0);
        drive(0, 0, 0, 128'hD, 0, 0);
        step();
        check_stage("idle_bubble", 0, 128'hC, 0, 0);

        // Both valid continuously: requester 1 wins every fifth cycle.
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1, width_lp'(32'h100 + i), 1, width_lp'(32'h200 + i));
            check($sformatf("starve_cnt%0d", i), width_lp'(arb_if.starve_cnt_o), width_lp'(cnt_seq[i]));
            check_ready($sformatf("starve%0d", i), !g1_seq[i], g1_seq[i]);
            step();
            check($sformatf("starve_res%0d", i), arb_if.reservation_o,
                  g1_seq[i] ? width_lp'(32'h200 + i) : width_lp'(32'h100 + i));
            check($sformatf("starve_src%0d", i), width_lp'(arb_if.src_o), width_lp'(g1_seq[i]));
        end
        check_stage("starve_end", 1, 128'h209, 1, 0);

        // Stage X, then stall three cycles with both valid.
        drive(0, 0, 1, 128'hAAA, 1, 128'hBBB);
        step();
        check_stage("stage_x", 1, 128'hAAA, 0, 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, width_lp'(32'h300 + i), 1, width_lp'(32'h400 + i));
            check_ready($sformatf("stall%0d", i), 0, 0);
            step();
            check_stage($sformatf("stall%0d", i), 1, 128'hAAA, 0, 1);
        end
        drive(0, 0, 1, 128'hCCC, 1, 128'hDDD);
        check_ready("stall_rel", 1, 0);
        step();
        check_stage("stall_rel", 1, 128'hCCC, 0, 2);

        // Flush with requester 1 waiting.
        drive(1, 0, 0, 0, 1, 128'hE1);
        check_ready("flush", 0, 0);
        step();
        check_stage("flush", 0, 128'hCCC, 0, 0);
        drive(0, 0, 0, 0, 1, 128'hE1);
        check_ready("post_flush", 0, 1);
        step();
        check_stage("post_flush", 1, 128'hE1, 1, 0);

        // Empty stage ignores stall.
        drive(0, 0, 0, 0, 0, 0);
        step();
        check_stage("drain", 0, 128'hE1, 1, 0);
        drive(0, 1, 0, 0, 1, 128'hF2);
        check_ready("empty_stall", 0, 1);
        step();
        check_stage("empty_stall", 1, 128'hF2, 1, 0);

        // Flush during stall empties the stage.
        drive(1, 1, 1, 128'h77, 0, 0);
        check_ready("flush_stall", 0, 0);
        step();
        check_stage("flush_stall", 0, 128'hF2, 1, 0);

        // Build nonzero state, then assert reset between edges.
        drive(0, 0, 1, 128'h99, 1, 128'h88);
        step();
        check_stage("pre_reset", 1, 128'h99, 0, 1);
        #2;
        reset_i = 1'b1;
        #1;
        check_stage("async_reset", 0, 0, 0, 0);
        check_ready("async_reset", 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        step();
        reset_i = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
